// File: rtl/axi4_lite_initiator.sv
// Single-outstanding AXI4-Lite initiator.
// Turns a simple command/response handshake into AW/W/B or AR/R channel traffic.
module axi4_lite_initiator #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter logic [2:0]  PROT          = 3'b000
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  // command side
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic                      i_cmd_write,
  input  logic [ADDRESS_WIDTH-1:0]  i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]     i_cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   i_cmd_wstrb,
  // response side
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic                      o_rsp_write,
  output logic [DATA_WIDTH-1:0]     o_rsp_rdata,
  output logic [1:0]                o_rsp_resp,
  // write address channel
  output logic                      o_awvalid,
  input  logic                      i_awready,
  output logic [ADDRESS_WIDTH-1:0]  o_awaddr,
  output logic [2:0]                o_awprot,
  // write data channel
  output logic                      o_wvalid,
  input  logic                      i_wready,
  output logic [DATA_WIDTH-1:0]     o_wdata,
  output logic [DATA_WIDTH/8-1:0]   o_wstrb,
  // write response channel
  input  logic                      i_bvalid,
  output logic                      o_bready,
  input  logic [1:0]                i_bresp,
  // read address channel
  output logic                      o_arvalid,
  input  logic                      i_arready,
  output logic [ADDRESS_WIDTH-1:0]  o_araddr,
  output logic [2:0]                o_arprot,
  // read data channel
  input  logic                      i_rvalid,
  output logic                      o_rready,
  input  logic [DATA_WIDTH-1:0]     i_rdata,
  input  logic [1:0]                i_rresp
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  // AXI4-Lite only defines 32- and 64-bit data buses
  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
    $error("axi4_lite_initiator: DATA_WIDTH must be 32 or 64");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_e;

  state_e                   state;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [STRB_WIDTH-1:0]    wstrb_q;
  logic                     write_q;
  logic                     aw_done;
  logic                     w_done;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic [1:0]               resp_q;

  logic cmd_hs;
  logic aw_hs;
  logic w_hs;
  logic aw_fin;
  logic w_fin;

  // Channel handshakes and per-channel completion including this cycle
  assign cmd_hs = i_cmd_valid & o_cmd_ready;
  assign aw_hs  = o_awvalid & i_awready;
  assign w_hs   = o_wvalid & i_wready;
  assign aw_fin = aw_done | aw_hs;
  assign w_fin  = w_done | w_hs;

  // Payloads come straight from the latched command so they stay stable while valid
  assign o_awaddr    = addr_q;
  assign o_araddr    = addr_q;
  assign o_wdata     = wdata_q;
  assign o_wstrb     = wstrb_q;
  assign o_awprot    = PROT;
  assign o_arprot    = PROT;
  assign o_rsp_write = write_q;
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_resp  = resp_q;

  // Transaction sequencer with registered handshake outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_cmd_ready <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_awvalid   <= 1'b0;
      o_wvalid    <= 1'b0;
      o_bready    <= 1'b0;
      o_arvalid   <= 1'b0;
      o_rready    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      write_q     <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rdata_q     <= '0;
      resp_q      <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_hs) begin
            addr_q      <= i_cmd_addr;
            wdata_q     <= i_cmd_wdata;
            wstrb_q     <= i_cmd_wstrb;
            write_q     <= i_cmd_write;
            o_cmd_ready <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            if (i_cmd_write) begin
              o_awvalid <= 1'b1;
              o_wvalid  <= 1'b1;
              state     <= WR_REQ;
            end else begin
              o_arvalid <= 1'b1;
              state     <= RD_REQ;
            end
          end else begin
            o_cmd_ready <= 1'b1;
          end
        end

        // AW and W retire independently; B is only accepted once both are done
        WR_REQ: begin
          if (aw_hs) begin
            o_awvalid <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            o_wvalid <= 1'b0;
            w_done   <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            o_bready <= 1'b1;
            state    <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (i_bvalid && o_bready) begin
            resp_q      <= i_bresp;
            rdata_q     <= '0;
            o_bready    <= 1'b0;
            o_rsp_valid <= 1'b1;
            state       <= RSP;
          end
        end

        RD_REQ: begin
          if (i_arready && o_arvalid) begin
            o_arvalid <= 1'b0;
            o_rready  <= 1'b1;
            state     <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (i_rvalid && o_rready) begin
            rdata_q     <= i_rdata;
            resp_q      <= i_rresp;
            o_rready    <= 1'b0;
            o_rsp_valid <= 1'b1;
            state       <= RSP;
          end
        end

        // Hold the response until consumed; command accepted again one cycle later
        RSP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_cmd_ready <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          o_cmd_ready <= 1'b0;
          o_rsp_valid <= 1'b0;
          o_awvalid   <= 1'b0;
          o_wvalid    <= 1'b0;
          o_bready    <= 1'b0;
          o_arvalid   <= 1'b0;
          o_rready    <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_initiator.sv
// Directed bench for axi4_lite_initiator: inputs change and outputs are sampled on the falling edge.
module tb_axi4_lite_initiator;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          awvalid;
  logic          awready;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          wvalid;
  logic          wready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          bvalid;
  logic          bready;
  logic [1:0]    bresp;
  logic          arvalid;
  logic          arready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;

  int checks;
  int errors;

  axi4_lite_initiator #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .PROT         (3'b000)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready),
    .i_cmd_write(cmd_write),
    .i_cmd_addr (cmd_addr),
    .i_cmd_wdata(cmd_wdata),
    .i_cmd_wstrb(cmd_wstrb),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_write(rsp_write),
    .o_rsp_rdata(rsp_rdata),
    .o_rsp_resp (rsp_resp),
    .o_awvalid  (awvalid),
    .i_awready  (awready),
    .o_awaddr   (awaddr),
    .o_awprot   (awprot),
    .o_wvalid   (wvalid),
    .i_wready   (wready),
    .o_wdata    (wdata),
    .o_wstrb    (wstrb),
    .i_bvalid   (bvalid),
    .o_bready   (bready),
    .i_bresp    (bresp),
    .o_arvalid  (arvalid),
    .i_arready  (arready),
    .o_araddr   (araddr),
    .o_arprot   (arprot),
    .i_rvalid   (rvalid),
    .o_rready   (rready),
    .i_rdata    (rdata),
    .i_rresp    (rresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready} !== 7'b0) begin
      errors++;
      $display("FAIL reset_handshakes got=%b exp=0000000",
               {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready});
    end
    checks++;
    if ({awaddr, wdata, wstrb, rsp_rdata, rsp_resp} !== '0) begin
      errors++;
      $display("FAIL reset_regs awaddr=%h wdata=%h wstrb=%h rdata=%h resp=%h exp all 0",
               awaddr, wdata, wstrb, rsp_rdata, rsp_resp);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready);
    end
  endtask

  task automatic test_read();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = 32'hFFFF_0000;
    checks++;
    if ({arvalid, awvalid, wvalid, cmd_ready} !== 4'b1000 || araddr !== 32'h20 || arprot !== 3'b000) begin
      errors++;
      $display("FAIL rd_ar got=%b araddr=%h arprot=%b exp=1000 araddr=20 arprot=000",
               {arvalid, awvalid, wvalid, cmd_ready}, araddr, arprot);
    end
    arready = 1'b1;
    @(negedge clk);
    checks++;
    if ({arvalid, rready, rsp_valid} !== 3'b010) begin
      errors++;
      $display("FAIL rd_r_phase got=%b exp=010", {arvalid, rready, rsp_valid});
    end
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
    @(negedge clk);
    rvalid = 1'b0; rdata = 32'h0;
    checks++;
    if ({rsp_valid, rsp_write, rready} !== 3'b100 || rsp_rdata !== 32'h1234_5678 || rsp_resp !== 2'b00) begin
      errors++;
      $display("FAIL rd_rsp got=%b rdata=%h resp=%h exp=100 rdata=12345678 resp=0",
               {rsp_valid, rsp_write, rready}, rsp_rdata, rsp_resp);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rd_idle got=%b exp=01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_write_zero_wait();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_cmd_ready got=%b exp=1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
    checks++;
    if ({awvalid, wvalid, bready, arvalid, cmd_ready} !== 5'b11000) begin
      errors++;
      $display("FAIL wr_valids got=%b exp=11000", {awvalid, wvalid, bready, arvalid, cmd_ready});
    end
    checks++;
    if (awaddr !== 32'h10 || wdata !== 32'hDEAD_BEEF || wstrb !== 4'hF || awprot !== 3'b000) begin
      errors++;
      $display("FAIL wr_payload awaddr=%h wdata=%h wstrb=%h awprot=%b exp 10 deadbeef f 000",
               awaddr, wdata, wstrb, awprot);
    end
    awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    checks++;
    if ({awvalid, wvalid, bready, rsp_valid} !== 4'b0010) begin
      errors++;
      $display("FAIL wr_b_phase got=%b exp=0010", {awvalid, wvalid, bready, rsp_valid});
    end
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
    @(negedge clk);
    bvalid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_write, bready} !== 3'b110 || rsp_rdata !== 32'h0 || rsp_resp !== 2'b00) begin
      errors++;
      $display("FAIL wr_rsp got=%b rdata=%h resp=%h exp=110 rdata=0 resp=0",
               {rsp_valid, rsp_write, bready}, rsp_rdata, rsp_resp);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL wr_idle got=%b exp=01", {rsp_valid, cmd_ready});
    end
  endtask

  // AW accepted at cycle 1, W at cycle 4; an early bvalid must be ignored until both are done
  task automatic test_skewed_write();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h44; cmd_wdata = 32'h0BAD_CAFE; cmd_wstrb = 4'h5;
    @(negedge clk);
    cmd_valid = 1'b0;
    awready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      awready = 1'b0;
      checks++;
      if ({awvalid, wvalid, bready} !== 3'b010 || wdata !== 32'h0BAD_CAFE || wstrb !== 4'h5) begin
        errors++;
        $display("FAIL skew_cycle%0d got=%b wdata=%h wstrb=%h exp=010 wdata=0badcafe wstrb=5",
                 c, {awvalid, wvalid, bready}, wdata, wstrb);
      end
    end
    wready = 1'b1;
    @(negedge clk);
    wready = 1'b0;
    checks++;
    if ({awvalid, wvalid, bready, rsp_valid} !== 4'b0010) begin
      errors++;
      $display("FAIL skew_bready got=%b exp=0010", {awvalid, wvalid, bready, rsp_valid});
    end
    @(negedge clk);
    bvalid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_write} !== 2'b11 || rsp_resp !== 2'b00) begin
      errors++;
      $display("FAIL skew_rsp got=%b resp=%h exp=11 resp=0", {rsp_valid, rsp_write}, rsp_resp);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_error_passthrough();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8; cmd_wdata = 32'h5; cmd_wstrb = 4'h1;
    @(negedge clk);
    cmd_valid = 1'b0; awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b10;
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_resp !== 2'b10 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL err_bresp valid=%b resp=%h rdata=%h exp valid=1 resp=2 rdata=0",
               rsp_valid, rsp_resp, rsp_rdata);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hC;
    @(negedge clk);
    cmd_valid = 1'b0; arready = 1'b1;
    @(negedge clk);
    arready = 1'b0; rvalid = 1'b1; rdata = 32'hA5A5_A5A5; rresp = 2'b11;
    @(negedge clk);
    rvalid = 1'b0; rresp = 2'b00;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_resp !== 2'b11 || rsp_rdata !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL err_rresp valid=%b resp=%h rdata=%h exp valid=1 resp=3 rdata=a5a5a5a5",
               rsp_valid, rsp_resp, rsp_rdata);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // Stalled response with a queued write behind it, then back-to-back acceptance
  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30;
    @(negedge clk);
    cmd_valid = 1'b0; arready = 1'b1;
    @(negedge clk);
    arready = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = 2'b00;
    @(negedge clk);
    rvalid = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h1122_3344; cmd_wstrb = 4'h3;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid, rsp_write, cmd_ready, awvalid} !== 4'b1000 || rsp_rdata !== 32'hCAFE_F00D || rsp_resp !== 2'b00) begin
        errors++;
        $display("FAIL bp_stall%0d got=%b rdata=%h resp=%h exp=1000 rdata=cafef00d resp=0",
                 i, {rsp_valid, rsp_write, cmd_ready, awvalid}, rsp_rdata, rsp_resp);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_same_cycle got=%b exp=0", cmd_ready);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release got=%b exp=01", {rsp_valid, cmd_ready});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({awvalid, wvalid, cmd_ready} !== 3'b110 || awaddr !== 32'h40 || wdata !== 32'h1122_3344 || wstrb !== 4'h3) begin
      errors++;
      $display("FAIL b2b_write got=%b awaddr=%h wdata=%h wstrb=%h exp=110 40 11223344 3",
               {awvalid, wvalid, cmd_ready}, awaddr, wdata, wstrb);
    end
    awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
    @(negedge clk);
    bvalid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_write} !== 2'b11 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL b2b_rsp got=%b rdata=%h exp=11 rdata=0", {rsp_valid, rsp_write}, rsp_rdata);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    logic saw_rsp;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h50; cmd_wdata = 32'h77; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({awvalid, wvalid} !== 2'b11) begin
      errors++;
      $display("FAIL rst_mid_pre got=%b exp=11", {awvalid, wvalid});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready} !== 7'b0) begin
      errors++;
      $display("FAIL rst_mid_async got=%b exp=0000000",
               {awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    bvalid = 1'b1; bresp = 2'b00;
    @(negedge clk);
    checks++;
    if ({cmd_ready, awvalid, wvalid, bready} !== 4'b1000) begin
      errors++;
      $display("FAIL rst_mid_idle got=%b exp=1000", {cmd_ready, awvalid, wvalid, bready});
    end
    saw_rsp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
    end
    bvalid = 1'b0;
    checks++;
    if (saw_rsp !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_no_rsp got=%b exp=0", saw_rsp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_read();
    test_write_zero_wait();
    test_skewed_write();
    test_error_passthrough();
    test_back_to_back();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_lite_initiator.md
Name: axi4_lite_initiator

Overview:
- Single-outstanding AXI4-Lite initiator (master) that drives the slave end of an AXI4-Lite interface from a simple command/response handshake.
- Host logic (CSR sequencers, test harnesses) issues one read or write command at a time.
- The block runs the AW/W/B or AR/R channel handshakes and returns read data plus response code.
- It is the counterpart to our AXI4-Lite slave/responder blocks.

Parameters:
- ADDRESS_WIDTH, 32, width of cmd/AXI address.
- DATA_WIDTH, 32, data width; must be 32 or 64.
- PROT, 3'b000, constant driven on awprot/arprot.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command accepted when high with i_cmd_valid
- i_cmd_write  in  1  1 = write, 0 = read
- i_cmd_addr  in  ADDRESS_WIDTH  target address
- i_cmd_wdata  in  DATA_WIDTH  write data
- i_cmd_wstrb  in  DATA_WIDTH/8  write strobes
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response consumed
- o_rsp_write  out  1  echo of command type
- o_rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- o_rsp_resp  out  2  bresp/rresp captured
- o_awvalid  out  1  write-address valid
- i_awready  in  1  write-address ready
- o_awaddr  out  ADDRESS_WIDTH  write address
- o_awprot  out  3  write protection type
- o_wvalid  out  1  write-data valid
- i_wready  in  1  write-data ready
- o_wdata  out  DATA_WIDTH  write data
- o_wstrb  out  DATA_WIDTH/8  write strobes
- i_bvalid  in  1  write-response valid
- o_bready  out  1  write-response ready
- i_bresp  in  2  write response code
- o_arvalid  out  1  read-address valid
- i_arready  in  1  read-address ready
- o_araddr  out  ADDRESS_WIDTH  read address
- o_arprot  out  3  read protection type
- i_rvalid  in  1  read-data valid
- o_rready  out  1  read-data ready
- i_rdata  in  DATA_WIDTH  read data
- i_rresp  in  2  read response code

Behaviour:
- Reset: every valid/ready output is 0, state is IDLE, and address/data/resp registers are 0. A reset mid-transaction abandons the transaction silently with no response.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - o_cmd_ready = 1 (registered, state==IDLE).
  - On cmd handshake, latch addr/wdata/wstrb/write.
  - Go to WR_REQ (write) or RD_REQ (read) on the next cycle.
- WR_REQ:
  - o_awvalid and o_wvalid both rise the cycle after the cmd handshake.
  - Each channel drops independently the cycle after its own handshake; flags aw_done/w_done track completion.
  - Same-cycle handshake of both channels is legal.
  - When both are done, go to WR_RESP.
  - Payload is held stable while valid is high.
- WR_RESP:
  - o_bready = 1.
  - On i_bvalid, capture i_bresp, set rdata = 0, go to RSP.
  - i_bvalid arriving before both AW and W complete is ignored: bready stays 0 until then.
- RD_REQ:
  - o_arvalid = 1 until i_arready.
  - Then go to RD_DATA.
- RD_DATA:
  - o_rready = 1.
  - On i_rvalid, capture i_rdata/i_rresp, go to RSP.
- RSP:
  - o_rsp_valid = 1, payload stable.
  - On i_rsp_ready, go to IDLE.
  - A new cmd is accepted at the earliest one cycle later.
- Minimum latency with a zero-wait slave: write cmd handshake at cycle 0 → AW/W handshake at cycle 1 → B at cycle 2 → o_rsp_valid at cycle 3. Reads follow the same count.
- No timeout: the block waits indefinitely on any channel.
- Response codes are passed through unmodified: 0 OKAY, 2 SLVERR, 3 DECERR.
- i_cmd_* is sampled only on handshake; later changes have no effect.

Test Plan:
- Write, zero-wait slave: addr 0x10, wdata 0xDEADBEEF, strb 0xF → AW/W valid at cycle 1 with matching payload; o_rsp_valid at cycle 3 with resp 0 and rdata 0.
- Read, slave rdata 0x12345678, rresp 0 → o_arvalid with araddr 0x20; o_rsp_rdata = 0x12345678, resp 0.
- Skewed write: awready at cycle 1, wready delayed to cycle 4 → awvalid low from cycle 2, wvalid held through cycle 4, bready first high at cycle 5.
- Error passthrough: bresp = 2 on write, rresp = 3 on read → o_rsp_resp = 2 and 3 respectively.
- Backpressure: i_rsp_ready low for 5 cycles → o_rsp_valid and payload stable; o_cmd_ready stays 0 until the cycle after i_rsp_ready.
- Reset asserted while in WR_REQ → all valids 0 immediately (asynchronous); IDLE with o_cmd_ready = 1 after release; no o_rsp_valid is produced.
